aes_axis_frame_parser: RTL
==========================

// Module: aes_axis_frame_parser
// PURPOSE
//  Front-end stage of the AES AXI-stream accelerator; sits between the DMA-fed AXI4-Stream slave and the AES core.
//  Receives 32-bit kernel words, decodes each frame's leading command word and un-swaps byte order.
//  Assembles 128-bit key/data blocks and hands them one at a time to the core over a valid/ready interface.
//  Malformed frames are flagged and discarded up to TLAST.
// PARAMETERS
//  WORD_S  32   AXI-stream data width (bits); only 32 supported
//  BLK_S   128  block / key width (bits); BLK_S/WORD_S = 4 words per block
// PORTS
//  clock          in   1      single clock, all logic rising-edge
//  reset          in   1      synchronous, active-high
//  s_axis_tdata   in   32     kernel word, little-endian byte order
//  s_axis_tvalid  in   1      upstream word valid
//  s_axis_tready  out  1      parser accepts word
//  s_axis_tlast   in   1      last word of frame
//  blk_data       out  128    [0:127] block/key, big-endian, word0 in bits 0:31
//  blk_cmd        out  2      0=SET_KEY, 1=ENCRYPT, 2=DECRYPT
//  blk_last       out  1      block is final one of its frame
//  blk_valid      out  1      block held for core
//  blk_ready      in   1      core takes block
//  frame_err      out  1      one-cycle pulse on malformed frame
// BEHAVIOUR
//  Reset: state=S_CMD, word_cnt=0, blk_valid=0, blk_data=0, blk_cmd=0, blk_last=0, frame_err=0, s_axis_tready=0 during reset.
//  Word transfer = tvalid & tready; block transfer = blk_valid & blk_ready.
//  Byte un-swap per word: {tdata[7:0],tdata[15:8],tdata[23:16],tdata[31:24]} -> blk_data[i*32 +: 32], i=word_cnt.
//  FSM:
//   S_CMD: accept word; decode CMD_SET_KEY=32'h20, CMD_ENCRYPT=32'h40, CMD_DECRYPT=32'h80 (raw tdata, no swap).
//    Valid cmd, tlast=0 -> S_COLLECT. Valid cmd with tlast=1 -> err pulse, stay S_CMD.
//    Unknown cmd -> err pulse; tlast=1 -> S_CMD, else -> S_DRAIN.
//   S_COLLECT: each word -> collect reg, word_cnt++ (2-bit, wraps 3->0).
//    On 4th word: move collect reg to output reg (blk_valid=1, blk_last=tlast).
//    Also on 4th word: tlast=1 -> S_CMD; SET_KEY with tlast=0 -> err, S_DRAIN; ENCRYPT/DECRYPT with tlast=0 -> stay S_COLLECT.
//    tlast on word 1..3 -> partial block dropped, err pulse, word_cnt=0, -> S_CMD.
//   S_DRAIN: tready=1, discard words until tlast accepted -> S_CMD.
//  Buffering: separate collect and output registers.
//   tready = !(state==S_COLLECT && word_cnt==3 && blk_valid && !blk_ready) in S_CMD/S_COLLECT/S_DRAIN.
//   Result: 4th word stalls only while the previous block is still unconsumed.
//   Sustains 1 word/cycle when the core is ready.
//  Latency: blk_valid rises the cycle after the 4th word transfer.
//   blk_data/cmd/last stable while blk_valid=1 && !blk_ready.
//  Simultaneous load + consume: new block overwrites output reg; blk_valid stays 1 with no bubble.
//  blk_valid falls the cycle after consumption when no new block is loaded.
//  frame_err: registered, 1 cycle, never sticky.
//  Reset mid-frame: all state cleared; the next accepted word is treated as a command.
// STRUCTURE
//  aes_pkg: WORD_S, BLK_S, KEY_S, CMD_* encodings, cmd_t enum (2-bit), swap_bytes32 function.
//  Sub-module axis_word_packer: word_cnt + collect reg + byte swap, with load/clear/full.
//  Parser FSM, drain logic and output register live in the top.
// TESTING
//  1 SET_KEY 32'h20, then words 7461_6854,796d_2073,6e75_4b20,7546_2067 (tlast on last)
//    -> one block: blk_cmd=0, blk_last=1, blk_data=5468_6174_7320_6d79_204b_756e_6720_4675.
//  2 ENCRYPT frame, 2 blocks (206f_7754,2065_6e4f,656e_694e,6f77_5420 then 7856_3412,4523_1191,2301_8967,0189_6745, tlast on last), blk_ready=1
//    -> blocks 5477_6f20_4f6e_6520_4e69_6e65_2054_776f (last=0) and 1234_5678_9111_2345_6789_0123_4567_8901 (last=1);
//    -> tready never drops.
//  3 Same as 2 with blk_ready held 0 for 10 cycles
//    -> tready low on 4th word of block 2 until first block taken; no data lost or reordered.
//  4 Cmd 32'hDEAD_BEEF + 4 words, tlast on last -> frame_err=1 once, no blk_valid, next SET_KEY frame parses correctly.
//  5 ENCRYPT with tlast on 2nd data word -> frame_err pulse, no block; following ENCRYPT frame yields correct block.
//  6 Assert reset after 2 data words -> outputs at reset values.
//    Following SET_KEY frame produces the key of test 1.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths, command encodings and byte-swap helper for the AES stream front end
package aes_pkg;

    localparam int WORD_S = 32;
    localparam int BLK_S  = 128;
    localparam int KEY_S  = 128;

    localparam logic [WORD_S-1:0] CMD_WORD_SET_KEY = 32'h0000_0020;
    localparam logic [WORD_S-1:0] CMD_WORD_ENCRYPT = 32'h0000_0040;
    localparam logic [WORD_S-1:0] CMD_WORD_DECRYPT = 32'h0000_0080;

    typedef enum logic [1:0] {
        CMD_SET_KEY = 2'd0,
        CMD_ENCRYPT = 2'd1,
        CMD_DECRYPT = 2'd2
    } cmd_t;

    typedef enum logic [1:0] {
        S_CMD     = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    // Kernel words arrive little-endian; the core expects big-endian bytes.
    function automatic logic [WORD_S-1:0] swap_bytes32(input logic [WORD_S-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_axis_frame_parser_if.sv
// rtl/aes_axis_frame_parser_if.sv - word stream in and block hand-off out of the frame parser
interface aes_axis_frame_parser_if;
    import aes_pkg::*;

    logic [WORD_S-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [0:BLK_S-1]  blk_data;
    cmd_t              blk_cmd;
    logic              blk_last;
    logic              blk_valid;
    logic              blk_ready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, blk_ready,
        output s_axis_tready, blk_data, blk_cmd, blk_last, blk_valid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, blk_ready,
        input  s_axis_tready, blk_data, blk_cmd, blk_last, blk_valid
    );

endinterface

// File: rtl/axis_word_packer.sv
// rtl/axis_word_packer.sv - byte-swaps kernel words and packs them into a 128-bit collect register
module axis_word_packer
    import aes_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [WORD_S-1:0] word_i,
    output logic [1:0]        word_cnt_o,
    output logic              full_o,
    output logic [0:BLK_S-1]  block_o
);

    logic [0:BLK_S-1] collect_q, collect_d;
    logic [1:0]       cnt_q, cnt_d;

    // block_o already contains the incoming word so the 4th word can go straight to the output register.
    always_comb begin
        block_o = collect_q;
        block_o[cnt_q*WORD_S +: WORD_S] = swap_bytes32(word_i);
    end

    always_comb begin
        collect_d = collect_q;
        cnt_d     = cnt_q;
        if (load_i) begin
            collect_d = block_o;
            cnt_d     = cnt_q + 2'd1;
        end
        if (clear_i) begin
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            collect_q <= '0;
            cnt_q     <= 2'd0;
        end else begin
            collect_q <= collect_d;
            cnt_q     <= cnt_d;
        end
    end

    assign word_cnt_o = cnt_q;
    assign full_o     = (cnt_q == 2'd3);

endmodule

// File: rtl/aes_axis_frame_parser.sv
// rtl/aes_axis_frame_parser.sv - decodes command frames and hands 128-bit key/data blocks to the AES core
module aes_axis_frame_parser
    import aes_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    aes_axis_frame_parser_if.slave  bus,
    output logic                    frame_err
);

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    cmd_t             cmd_dec;
    logic             cmd_ok;
    logic             tready, word_xfer, tlast;
    logic             pk_load, pk_clear, pk_full, out_load, err_d;
    logic [1:0]       word_cnt;
    logic [0:BLK_S-1] pk_block;
    logic [0:BLK_S-1] blk_data_q;
    cmd_t             blk_cmd_q;
    logic             blk_last_q, blk_valid_q, frame_err_q;

    // Only the block-completing word ever stalls, and only while the output register is still occupied.
    assign tready    = !reset && !(state_q == S_COLLECT && pk_full && blk_valid_q && !bus.blk_ready);
    assign word_xfer = bus.s_axis_tvalid && tready;
    assign tlast     = bus.s_axis_tlast;

    always_comb begin
        cmd_ok  = 1'b1;
        cmd_dec = CMD_SET_KEY;
        case (bus.s_axis_tdata)
            CMD_WORD_SET_KEY: cmd_dec = CMD_SET_KEY;
            CMD_WORD_ENCRYPT: cmd_dec = CMD_ENCRYPT;
            CMD_WORD_DECRYPT: cmd_dec = CMD_DECRYPT;
            default:          cmd_ok  = 1'b0;
        endcase
    end

    axis_word_packer u_packer (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (pk_load),
        .clear_i    (pk_clear),
        .word_i     (bus.s_axis_tdata),
        .word_cnt_o (word_cnt),
        .full_o     (pk_full),
        .block_o    (pk_block)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_CMD;
            cmd_q   <= CMD_SET_KEY;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CMD: begin
                if (word_xfer && !tlast) state_d = cmd_ok ? S_COLLECT : S_DRAIN;
            end
            S_COLLECT: begin
                if (word_xfer) begin
                    if (tlast)                                 state_d = S_CMD;
                    else if (pk_full && cmd_q == CMD_SET_KEY)  state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (word_xfer && tlast) state_d = S_CMD;
            end
            default: state_d = S_CMD;
        endcase
    end

    always_comb begin
        cmd_d    = cmd_q;
        pk_load  = 1'b0;
        pk_clear = 1'b0;
        out_load = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_CMD: begin
                if (word_xfer) begin
                    cmd_d = cmd_dec;
                    err_d = !cmd_ok || tlast;
                end
            end
            S_COLLECT: begin
                if (word_xfer) begin
                    pk_load = 1'b1;
                    if (pk_full) begin
                        out_load = 1'b1;
                        err_d    = !tlast && (cmd_q == CMD_SET_KEY);
                    end else if (tlast) begin
                        pk_clear = 1'b1;
                        err_d    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blk_data_q  <= '0;
            blk_cmd_q   <= CMD_SET_KEY;
            blk_last_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= err_d;
            if (out_load) begin
                blk_data_q  <= pk_block;
                blk_cmd_q   <= cmd_q;
                blk_last_q  <= tlast;
                blk_valid_q <= 1'b1;
            end else if (blk_valid_q && bus.blk_ready) begin
                blk_valid_q <= 1'b0;
            end
        end
    end

    assign bus.s_axis_tready = tready;
    assign bus.blk_data      = blk_data_q;
    assign bus.blk_cmd       = blk_cmd_q;
    assign bus.blk_last      = blk_last_q;
    assign bus.blk_valid     = blk_valid_q;
    assign frame_err         = frame_err_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, word_cnt, KEY_S[0]};

endmodule
